// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared definitions for the sequential restoring divider.
//   state_e   : controller state encoding (IDLE / RUN / DONE)
//   cnt_width : width of the iteration counter for a given operand width,
//               $clog2(WIDTH+1) so the counter can hold the value WIDTH.
package seq_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_div_ctrl.sv
// seq_div_ctrl: controller for the sequential divider (FSM + iteration counter).
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   start         : division request, honoured only in IDLE
//   divisor_zero  : divisor presented with start is zero
//   load          : accept a normal division (datapath loads operands)
//   zero_load     : accept a divide-by-zero (datapath registers the fixed result)
//   shift         : one restoring iteration this cycle
//   finish        : last iteration; datapath registers the result
//   busy, done    : Moore status, busy in RUN, done in DONE
module seq_div_ctrl
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic divisor_zero,
  output logic load,
  output logic zero_load,
  output logic shift,
  output logic finish,
  output logic busy,
  output logic done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load      = 1'b0;
    zero_load = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor_zero) begin
            // Result is fixed; skip the iterations entirely.
            zero_load = 1'b1;
            state_d   = ST_DONE;
          end else begin
            load    = 1'b1;
            count_d = {CNT_W{1'b0}};
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        shift   = 1'b1;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
// Optional build macro SEQ_DIVIDER_SIGNED_EN: two's complement operands
// (magnitudes divided, signs applied when the result is registered).
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   start               : request a division (accepted only in IDLE)
//   dividend, divisor   : operands, sampled on the accepting edge
//   busy                : high while iterating
//   done                : one-cycle pulse, result valid
//   quotient, remainder : result, held until the next result is registered
//   div_by_zero         : divisor was zero for the current result
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic load_s, zero_load_s, shift_s, finish_s, divisor_zero_s;

  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, m_q, m_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted_s, trial_s;
  logic [WIDTH-1:0] r_next_s, q_next_s;
  logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s, quot_fin_s, rem_fin_s;

  assign divisor_zero_s = (divisor == {WIDTH{1'b0}});

  seq_div_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .divisor_zero (divisor_zero_s),
    .load         (load_s),
    .zero_load    (zero_load_s),
    .shift        (shift_s),
    .finish       (finish_s),
    .busy         (busy),
    .done         (done)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  function automatic logic [WIDTH-1:0] negate_if(input logic neg, input logic [WIDTH-1:0] v);
    if (neg) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // The most-negative value maps to itself, which the unsigned engine reads
  // as 2^(WIDTH-1); that makes most-negative / -1 wrap back to most-negative.
  assign dvd_mag_s  = negate_if(dividend[WIDTH-1], dividend);
  assign dvs_mag_s  = negate_if(divisor[WIDTH-1], divisor);
  assign quot_fin_s = negate_if(q_neg_q, q_next_s);
  assign rem_fin_s  = negate_if(r_neg_q, r_next_s);

  // Result sign flags captured with the operands.
  always_comb begin
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (load_s) begin
      q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_d = dividend[WIDTH-1];
    end else begin
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
    end
  end

  // Sign flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end
`else
  assign dvd_mag_s  = dividend;
  assign dvs_mag_s  = divisor;
  assign quot_fin_s = q_next_s;
  assign rem_fin_s  = r_next_s;
`endif

  // One restoring step. The shifted-out MSB of R is kept so the trial is
  // exact; it is always 0 here because R stays below the partial dividend.
  always_comb begin
    shifted_s = {r_q, q_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, m_q};
    if (trial_s[WIDTH]) begin
      r_next_s = shifted_s[WIDTH-1:0];
    end else begin
      r_next_s = trial_s[WIDTH-1:0];
    end
    q_next_s = {q_q[WIDTH-2:0], ~trial_s[WIDTH]};
  end

  // Datapath register next-values driven by the controller strobes.
  always_comb begin
    r_d         = r_q;
    q_d         = q_q;
    m_d         = m_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (load_s) begin
      r_d   = {WIDTH{1'b0}};
      q_d   = dvd_mag_s;
      m_d   = dvs_mag_s;
      dbz_d = 1'b0;
    end else if (zero_load_s) begin
      quotient_d  = {WIDTH{1'b1}};
      remainder_d = dividend;
      dbz_d       = 1'b1;
    end else if (shift_s) begin
      r_d = r_next_s;
      q_d = q_next_s;
      if (finish_s) begin
        quotient_d  = quot_fin_s;
        remainder_d = rem_fin_s;
      end else begin
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
      end
    end else begin
      r_d = r_q;
      q_d = q_q;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= {WIDTH{1'b0}};
      q_q         <= {WIDTH{1'b0}};
      m_q         <= {WIDTH{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
    end else begin
      r_q         <= r_d;
      q_q         <= q_d;
      m_q         <= m_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=4).
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    int sa, sb;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Issue one division from an IDLE cycle; returns at the first IDLE cycle
  // after DONE. lat = edges after the accepting edge until done is seen.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                         output int lat, output int bcnt);
    start = 1'b1; dividend = a; divisor = b;
    lat = 0; bcnt = 0;
    tick;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      start = noise; dividend = W'($urandom); divisor = W'($urandom);
      tick;
      lat++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    q = quotient; r = remainder; z = div_by_zero;
    check("busy_in_done", 32'(busy), 32'd0);
    start = noise; dividend = W'($urandom); divisor = W'($urandom);
    tick;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("result_held", {quotient, remainder}, {q, r});
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] q, r, eq, er;
    logic         z, ez;
    int           lat, bcnt;
    bit           seen;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick; tick;
    rst = 1'b0;
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    tbl.push_back('{a: 4'h9, b: 4'h2, q: 4'hD, r: 4'hF, z: 1'b0});
    tbl.push_back('{a: 4'h8, b: 4'hF, q: 4'h8, r: 4'h0, z: 1'b0});
    tbl.push_back('{a: 4'h7, b: 4'h0, q: 4'hF, r: 4'h7, z: 1'b1});
    tbl.push_back('{a: 4'h7, b: 4'h2, q: 4'h3, r: 4'h1, z: 1'b0});
`else
    tbl.push_back('{a: 4'd13, b: 4'd3, q: 4'd4,  r: 4'd1, z: 1'b0});
    tbl.push_back('{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, z: 1'b0});
    tbl.push_back('{a: 4'd0,  b: 4'd7, q: 4'd0,  r: 4'd0, z: 1'b0});
    tbl.push_back('{a: 4'd7,  b: 4'd0, q: 4'd15, r: 4'd7, z: 1'b1});
    tbl.push_back('{a: 4'd9,  b: 4'd2, q: 4'd4,  r: 4'd1, z: 1'b0});
    tbl.push_back('{a: 4'd14, b: 4'd5, q: 4'd2,  r: 4'd4, z: 1'b0});
`endif

    // Table vectors, back-to-back (each start in the first IDLE cycle).
    foreach (tbl[i]) begin
      run_div(tbl[i].a, tbl[i].b, 1'b0, q, r, z, lat, bcnt);
      check($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].q));
      check($sformatf("tbl%0d_r", i), 32'(r), 32'(tbl[i].r));
      check($sformatf("tbl%0d_dbz", i), 32'(z), 32'(tbl[i].z));
      check($sformatf("tbl%0d_lat", i), 32'(lat), tbl[i].z ? 32'd0 : 32'(W));
      check($sformatf("tbl%0d_busy_cnt", i), 32'(bcnt), tbl[i].z ? 32'd0 : 32'(W));
    end

    // start held high through RUN and DONE must be ignored.
    model(4'd15, 4'd1, eq, er, ez);
    run_div(4'd15, 4'd1, 1'b1, q, r, z, lat, bcnt);
    check("noise_q", 32'(q), 32'(eq));
    check("noise_r", 32'(r), 32'(er));
    check("noise_lat", 32'(lat), 32'(W));
    tick;
    check("noise_no_restart", 32'(busy), 32'd0);

    // Reset at iteration 2 of 14/5.
    start = 1'b1; dividend = 4'd14; divisor = 4'd5;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_quotient", 32'(quotient), 32'd0);
    check("mid_rst_remainder", 32'(remainder), 32'd0);
    check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen = 1'b1;
      tick;
    end
    check("mid_rst_no_done", 32'(seen), 32'd0);
    model(4'd14, 4'd5, eq, er, ez);
    run_div(4'd14, 4'd5, 1'b0, q, r, z, lat, bcnt);
    check("post_rst_q", 32'(q), 32'(eq));
    check("post_rst_r", 32'(r), 32'(er));

    // Exhaustive sweep against the reference.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        model(W'(a), W'(b), eq, er, ez);
        run_div(W'(a), W'(b), 1'b0, q, r, z, lat, bcnt);
        check($sformatf("sweep_%0d_%0d_q", a, b), 32'(q), 32'(eq));
        check($sformatf("sweep_%0d_%0d_r", a, b), 32'(r), 32'(er));
        check($sformatf("sweep_%0d_%0d_dbz", a, b), 32'(z), 32'(ez));
        check($sformatf("sweep_%0d_%0d_lat", a, b), 32'(lat), (b == 0) ? 32'd0 : 32'(W));
`ifndef SEQ_DIVIDER_SIGNED_EN
        if (b != 0) begin
          check($sformatf("inv_%0d_%0d", a, b), 32'(int'(q) * b + int'(r)), 32'(a));
          check($sformatf("rem_lt_%0d_%0d", a, b), 32'(int'(r) < b), 32'd1);
        end
`endif
      end
    end

    // Random operands, random start noise and idle gaps.
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      model(ra, rb, eq, er, ez);
      run_div(ra, rb, 1'($urandom_range(0, 1)), q, r, z, lat, bcnt);
      check($sformatf("rand%0d_q", n), 32'(q), 32'(eq));
      check($sformatf("rand%0d_r", n), 32'(r), 32'(er));
      check($sformatf("rand%0d_dbz", n), 32'(z), 32'(ez));
      repeat ($urandom_range(0, 2)) tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring divider: WIDTH-bit unsigned dividend / divisor, one quotient bit per clock.
Inverse companion of the team's shift-add sequential multiplier; shares its start/done handshake and controller/datapath split.
Sits beside the multiplier in the arithmetic unit and is driven by the same sequencer.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (WIDTH >= 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request a division; accepted only in IDLE
dividend  input  WIDTH  numerator; sampled on the accepting edge
divisor  input  WIDTH  denominator; sampled on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
quotient  output  WIDTH  result quotient; held until next accepted start
remainder  output  WIDTH  result remainder; held until next accepted start
div_by_zero  output  1  divisor was zero for the current result; held with the result

Behaviour:
- Reset is synchronous (rst sampled on posedge clk) with priority over everything, including mid-operation.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE), Moore.
- Transitions from IDLE:
  - start=1 and divisor!=0 at edge k: load Q=dividend, R=0, M=divisor, count=0, div_by_zero=0. Go to RUN.
  - start=1 and divisor==0 at edge k: quotient=all ones, remainder=dividend, div_by_zero=1. Go to DONE. done is high in the cycle after edge k.
- RUN iteration, one per edge at edges k+1 .. k+WIDTH:
  - Shift {R,Q} left by 1.
  - trial = {1'b0,R_shifted} - {1'b0,M}, computed at WIDTH+1 bits.
  - If trial[WIDTH]==0: R=trial[WIDTH-1:0] and Q[0]=1. Otherwise R is kept (restore) and Q[0]=0.
  - count increments each iteration. The iteration with count==WIDTH-1 moves to DONE and registers quotient=Q and remainder=R.
- Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after the accepting edge.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- start is ignored in RUN and DONE; no queuing. The earliest new acceptance is the first IDLE cycle after DONE.
- Input changes on dividend/divisor after the accepting edge have no effect.
- Result outputs are updated only on entry to DONE (or on reset). Between operations they hold the last result.
- Invariant (unsigned, divisor!=0): dividend == quotient*divisor + remainder, and remainder < divisor.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are divided by the same unsigned engine.
  - Sign is applied when registering the result: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Overflow: most-negative / -1 gives quotient=most-negative, remainder=0, no flag.
  - Divide by zero: quotient=all ones (-1), remainder=dividend, div_by_zero=1.
  - Latency is unchanged.
- Undefined: purely unsigned operation; no sign logic synthesised.

Decomposition:
- Shared package/include seq_div_pkg:
  - State encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
  - Counter width constant CNT_W = $clog2(WIDTH+1).
- Sub-module seq_div_ctrl: FSM plus iteration counter. Outputs load/shift/finish strobes, busy and done.
- The top holds the R/Q/M datapath registers and the trial subtractor, mirroring the multiplier's controller/datapath split.

Test Plan (WIDTH=4):
- 13/3: start at edge k -> done high only in the cycle after edge k+4; quotient=4, remainder=1, div_by_zero=0; busy high for exactly 4 cycles.
- 15/1 then 0/7 back-to-back (second start in the first IDLE cycle after DONE) -> (15,0) then (0,0). start pulsed during RUN and DONE is ignored.
- 7/0 -> done in the cycle after the accepting edge; quotient=15, remainder=7, div_by_zero=1. A following 9/2 -> (4,1) with div_by_zero cleared.
- rst asserted for one edge at iteration 2 of 14/5 -> all outputs 0, state IDLE, no done pulse; a subsequent 14/5 -> (2,4).
- Exhaustive sweep of all 256 dividend/divisor pairs, checked against a reference model: invariant holds; each done lasts exactly 1 cycle.
- With SEQ_DIVIDER_SIGNED_EN: -7/2 -> quotient=-3 (4'hD), remainder=-1 (4'hF); -8/-1 -> quotient=4'h8, remainder=0.
